// File: rtl/pipeline_arbiter_pkg.sv
// Shared types and helpers for the pipeline arbiter.
// Requester IDs are sized for the largest supported arbiter (16 requesters),
// so the {vld, id} shadow entry has one fixed layout for every NUM_REQ.
package pipeline_arbiter_pkg;

  localparam int MAX_REQ = 16;

  // clog2(n), never less than one bit.
  function automatic int id_width(input int n);
    if (n > 1) return $clog2(n);
    return 1;
  endfunction

  localparam int ID_W = id_width(MAX_REQ);

  typedef logic [ID_W-1:0]    req_id_t;
  typedef logic [MAX_REQ-1:0] req_vec_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } shadow_t;

  function automatic req_id_t onehot_to_idx(input req_vec_t oh);
    req_id_t idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = idx | req_id_t'(i);
    return idx;
  endfunction

  function automatic req_vec_t idx_to_onehot(input req_id_t idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/pipeline_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the
// external datapath.
//   master : arbiter view (drives req_ready, dp_in, rsp_*, busy)
//   slave  : requester/datapath view (drives req_valid, req_data, dp_out)
interface pipeline_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int BIT_WIDTH = 10
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*BIT_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [BIT_WIDTH-1:0]         dp_in;
  logic [BIT_WIDTH-1:0]         dp_out;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [BIT_WIDTH-1:0]         rsp_data;
  logic                         busy;

  modport master (
    input  req_valid, req_data, dp_out,
    output req_ready, dp_in, rsp_valid, rsp_data, busy
  );

  modport slave (
    output req_valid, req_data, dp_out,
    input  req_ready, dp_in, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/pipeline_arbiter_rr_grant.sv
// Combinational round-robin grant: picks the first valid requester at or
// after rr_ptr (ascending, wrapping).
//   req_valid : per-requester valid (already masked during reset/flush)
//   rr_ptr    : index with highest priority this cycle
//   grant     : one-hot grant, zero when nothing is valid
//   grant_idx : index of the granted requester (0 when no grant)
module pipeline_arbiter_rr_grant
  import pipeline_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  req_id_t            rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output req_id_t            grant_idx
);

  always_comb begin
    logic found;
    int   j;
    grant = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign grant_idx = onehot_to_idx(req_vec_t'(grant));

endmodule

// File: rtl/pipeline_arbiter.sv
// Round-robin arbiter and result router for a shared, stall-free,
// fixed-latency external datapath.
//   clk, rst : clock, synchronous active-high reset
//   flush    : (only with PIPELINE_ARBITER_FLUSH_EN) drops everything in flight
//   bus      : pipeline_arbiter_if.master - requests, datapath in/out,
//              one-hot result strobe, busy
// Optional feature macro: PIPELINE_ARBITER_FLUSH_EN.
// A shadow pipe of {vld, id} entries, one per datapath stage, tracks which
// requester owns the word currently leaving the datapath.
module pipeline_arbiter
  import pipeline_arbiter_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int BIT_WIDTH        = 10,
  parameter int NUMBER_OF_STAGES = 5
) (
  input logic clk,
  input logic rst,
`ifdef PIPELINE_ARBITER_FLUSH_EN
  input logic flush,
`endif
  pipeline_arbiter_if.master bus
);

  logic                 block;
  logic [NUM_REQ-1:0]   grant;
  req_id_t              grant_idx;
  req_id_t              rr_ptr;
  req_id_t              ptr_next;
  logic                 handshake;
  logic [BIT_WIDTH-1:0] sel_data;
  logic [BIT_WIDTH-1:0] dp_in_p0;
  shadow_t              iss_p0;
  shadow_t              sh_p [NUMBER_OF_STAGES+1];
  shadow_t              tail;
  logic                 busy_c;

`ifdef PIPELINE_ARBITER_FLUSH_EN
  assign block = rst | flush;
`else
  assign block = rst;
`endif

  // Masking valid (rather than the grant) keeps grant_idx at 0 while blocked.
  pipeline_arbiter_rr_grant #(.NUM_REQ(NUM_REQ)) u_grant (
    .req_valid (bus.req_valid & ~{NUM_REQ{block}}),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = grant;
  assign handshake     = |grant;
  assign sel_data      = bus.req_data[int'(grant_idx)*BIT_WIDTH +: BIT_WIDTH];
  assign ptr_next      = (grant_idx == req_id_t'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

  // Issue stage: p0 feeds the datapath input. A flush needs no term here
  // because it already suppresses the grant, so nothing new issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_in_p0 <= '0;
      iss_p0   <= '0;
      rr_ptr   <= '0;
    end else if (handshake) begin
      dp_in_p0 <= sel_data;
      iss_p0   <= '{vld: 1'b1, id: grant_idx};
      rr_ptr   <= ptr_next;
    end else begin
      iss_p0.vld <= 1'b0;
    end
  end

  assign bus.dp_in = dp_in_p0;

  // Shadow stages p1..pN mirror the datapath registers. With zero stages the
  // loop is empty and the tail is the issue register itself.
  assign sh_p[0] = iss_p0;

  for (genvar g = 1; g <= NUMBER_OF_STAGES; g++) begin : g_shadow
    always_ff @(posedge clk) begin
      if (block) sh_p[g] <= '0;
      else       sh_p[g] <= sh_p[g-1];
    end
  end

  assign tail = sh_p[NUMBER_OF_STAGES];

  always_comb begin
    busy_c = iss_p0.vld;
    for (int g = 1; g <= NUMBER_OF_STAGES; g++)
      busy_c = busy_c | sh_p[g].vld;
  end

  assign bus.busy      = busy_c;
  assign bus.rsp_valid = tail.vld ? NUM_REQ'(idx_to_onehot(tail.id)) : '0;
  assign bus.rsp_data  = bus.dp_out;

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Directed bench for pipeline_arbiter (4 requesters, 10-bit words, 5 stages).
// The external datapath is a 5-register delay line driven from dp_in.
module tb_pipeline_arbiter;

  localparam int NR = 4;
  localparam int BW = 10;
  localparam int NS = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef PIPELINE_ARBITER_FLUSH_EN
  logic flush = 1'b0;
`endif

  pipeline_arbiter_if #(.NUM_REQ(NR), .BIT_WIDTH(BW)) bus ();

  pipeline_arbiter #(
    .NUM_REQ          (NR),
    .BIT_WIDTH        (BW),
    .NUMBER_OF_STAGES (NS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef PIPELINE_ARBITER_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] dline [NS];
  always @(posedge clk) begin
    dline[0] <= bus.dp_in;
    for (int i = 1; i < NS; i++) dline[i] <= dline[i-1];
  end
  assign bus.dp_out = dline[NS-1];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [NR-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < NR; i++) if (oh[i]) r = i;
    return r;
  endfunction

  typedef struct packed {
    logic [NR-1:0] v;
    logic [NR-1:0] rdy;
    logic [NR-1:0] rsp;
    logic          bsy;
    logic [BW-1:0] dp;
  } vec_t;

  vec_t tbl [30];

  initial begin
    // Round robin with all four valid, then drain.
    tbl[0]  = '{4'hF, 4'h1, 4'h0, 1'b0, 10'h000};
    tbl[1]  = '{4'hF, 4'h2, 4'h0, 1'b1, 10'h3A0};
    tbl[2]  = '{4'hF, 4'h4, 4'h0, 1'b1, 10'h3A1};
    tbl[3]  = '{4'hF, 4'h8, 4'h0, 1'b1, 10'h3A2};
    tbl[4]  = '{4'hF, 4'h1, 4'h0, 1'b1, 10'h3A3};
    tbl[5]  = '{4'hF, 4'h2, 4'h0, 1'b1, 10'h3A0};
    tbl[6]  = '{4'hF, 4'h4, 4'h1, 1'b1, 10'h3A1};
    tbl[7]  = '{4'hF, 4'h8, 4'h2, 1'b1, 10'h3A2};
    tbl[8]  = '{4'hF, 4'h1, 4'h4, 1'b1, 10'h3A3};
    tbl[9]  = '{4'hF, 4'h2, 4'h8, 1'b1, 10'h3A0};
    tbl[10] = '{4'hF, 4'h4, 4'h1, 1'b1, 10'h3A1};
    tbl[11] = '{4'hF, 4'h8, 4'h2, 1'b1, 10'h3A2};
    tbl[12] = '{4'h0, 4'h0, 4'h4, 1'b1, 10'h3A3};
    tbl[13] = '{4'h0, 4'h0, 4'h8, 1'b1, 10'h3A3};
    tbl[14] = '{4'h0, 4'h0, 4'h1, 1'b1, 10'h3A3};
    tbl[15] = '{4'h0, 4'h0, 4'h2, 1'b1, 10'h3A3};
    tbl[16] = '{4'h0, 4'h0, 4'h4, 1'b1, 10'h3A3};
    tbl[17] = '{4'h0, 4'h0, 4'h8, 1'b1, 10'h3A3};
    tbl[18] = '{4'h0, 4'h0, 4'h0, 1'b0, 10'h3A3};
    // Requester 1 alone moves rr_ptr to 2, then 1 and 3 compete.
    tbl[19] = '{4'h2, 4'h2, 4'h0, 1'b0, 10'h3A3};
    tbl[20] = '{4'hA, 4'h8, 4'h0, 1'b1, 10'h3A1};
    tbl[21] = '{4'hA, 4'h2, 4'h0, 1'b1, 10'h3A3};
    tbl[22] = '{4'hA, 4'h8, 4'h0, 1'b1, 10'h3A1};
    tbl[23] = '{4'h0, 4'h0, 4'h0, 1'b1, 10'h3A3};
    tbl[24] = '{4'h0, 4'h0, 4'h0, 1'b1, 10'h3A3};
    tbl[25] = '{4'h0, 4'h0, 4'h2, 1'b1, 10'h3A3};
    tbl[26] = '{4'h0, 4'h0, 4'h8, 1'b1, 10'h3A3};
    tbl[27] = '{4'h0, 4'h0, 4'h2, 1'b1, 10'h3A3};
    tbl[28] = '{4'h0, 4'h0, 4'h8, 1'b1, 10'h3A3};
    tbl[29] = '{4'h0, 4'h0, 4'h0, 1'b0, 10'h3A3};

    // Reset held with every requester valid: no grant may leak out.
    bus.req_valid = 4'hF;
    bus.req_data  = {10'h3A3, 10'h3A2, 10'h3A1, 10'h3A0};
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      next_cycle();
    end
    rst = 1'b0;
    bus.req_valid = 4'h0;

    // Idle after reset.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_ready", 32'(bus.req_ready), 32'h0);
      chk("idle_rsp",   32'(bus.rsp_valid), 32'h0);
      chk("idle_busy",  32'(bus.busy),      32'h0);
      chk("idle_dp_in", 32'(bus.dp_in),     32'h0);
      next_cycle();
    end

    // Single request from requester 2.
    bus.req_data[2*BW +: BW] = 10'h155;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", 32'(bus.req_ready), 32'h4);
    next_cycle();
    bus.req_valid = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) chk("single_dp_in", 32'(bus.dp_in), 32'h155);
      chk("single_rsp",  32'(bus.rsp_valid), (k == 6) ? 32'h4 : 32'h0);
      chk("single_busy", 32'(bus.busy),      (k <= 6) ? 32'h1 : 32'h0);
      if (k == 6) chk("single_rsp_data", 32'(bus.rsp_data), 32'h155);
      next_cycle();
    end

    // Reset pulse returns rr_ptr to 0 before the table.
    bus.req_data = {10'h3A3, 10'h3A2, 10'h3A1, 10'h3A0};
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;

    for (int c = 0; c < 30; c++) begin
      bus.req_valid = tbl[c].v;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", c), 32'(bus.req_ready), 32'(tbl[c].rdy));
      chk($sformatf("tbl%0d_rsp",   c), 32'(bus.rsp_valid), 32'(tbl[c].rsp));
      chk($sformatf("tbl%0d_busy",  c), 32'(bus.busy),      32'(tbl[c].bsy));
      chk($sformatf("tbl%0d_dp_in", c), 32'(bus.dp_in),     32'(tbl[c].dp));
      if (tbl[c].rsp != '0)
        chk($sformatf("tbl%0d_rsp_data", c), 32'(bus.rsp_data),
            32'(10'h3A0) + 32'(oh_idx(tbl[c].rsp)));
      next_cycle();
    end

    // Three requests in flight (0,1,2), then reset: nothing comes back.
    bus.req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstmid_ready", 32'(bus.req_ready), 32'(1) << k);
      next_cycle();
    end
    bus.req_valid = 4'b1001;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_ready_in_rst", 32'(bus.req_ready), 32'h0);
    next_cycle();
    rst = 1'b0;
    bus.req_valid = 4'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rstmid_rsp",   32'(bus.rsp_valid), 32'h0);
      chk("rstmid_busy",  32'(bus.busy),      32'h0);
      chk("rstmid_dp_in", 32'(bus.dp_in),     32'h0);
      next_cycle();
    end
    // rr_ptr was 3 before reset; after reset requester 0 must win over 3.
    bus.req_valid = 4'b1001;
    @(negedge clk);
    chk("rstmid_regrant", 32'(bus.req_ready), 32'h1);
    next_cycle();
    bus.req_valid = 4'h0;
    @(negedge clk);
    chk("rstmid_regrant_dp", 32'(bus.dp_in), 32'h3A0);
    next_cycle();

`ifdef PIPELINE_ARBITER_FLUSH_EN
    // rr_ptr = 1: requesters 1 and 2 issue, flush kills them, 3 issues after.
    bus.req_valid = 4'hF;
    @(negedge clk);
    chk("flush_grant1", 32'(bus.req_ready), 32'h2);
    next_cycle();
    @(negedge clk);
    chk("flush_grant2", 32'(bus.req_ready), 32'h4);
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 32'(bus.req_ready), 32'h0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_after_ready", 32'(bus.req_ready), 32'h8);
    chk("flush_dp_hold",     32'(bus.dp_in),     32'h3A2);
    chk("flush_busy",        32'(bus.busy),      32'h0);
    chk("flush_rsp0",        32'(bus.rsp_valid), 32'h0);
    next_cycle();
    bus.req_valid = 4'h0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) chk("flush_dp_new", 32'(bus.dp_in), 32'h3A3);
      chk("flush_rsp", 32'(bus.rsp_valid), (k == 6) ? 32'h8 : 32'h0);
      next_cycle();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_arbiter.md
# pipeline_arbiter

Round-robin arbiter and result router that shares one fixed-latency, stall-free pipelined datapath among NUM_REQ requesters. It accepts one request per cycle via valid/ready and drives the datapath input from an issue register. A shadow pipeline of valid bits and requester IDs runs alongside the datapath and steers each result back to its originating requester. The datapath itself is instantiated outside this block and carries no valid or reset.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- BIT_WIDTH, 10, datapath word width
- NUMBER_OF_STAGES, 5, register stages in the external datapath (0 allowed)
- clk  input  1  sole clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_data  input  NUM_REQ*BIT_WIDTH  request words; requester i occupies bits [BIT_WIDTH*(i+1)-1 : BIT_WIDTH*i]
- req_ready  output  NUM_REQ  one-hot (or zero) grant
- dp_in  output  BIT_WIDTH  issue register driving the datapath input
- dp_out  input  BIT_WIDTH  datapath output
- rsp_valid  output  NUM_REQ  one-hot result strobe
- rsp_data  output  BIT_WIDTH  result word, equal to dp_out
- busy  output  1  high while any issued request has not yet returned

## Operation
- Grant: req_ready[i] = 1 only for the first valid requester at or after rr_ptr in ascending order, with wrap-around. All req_ready are 0 if no requester is valid, or while rst (or flush) is high.
- req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready. Once asserted, req_valid and req_data stay stable until the handshake.
- Handshake (valid & ready) at edge t:
  - dp_in <= selected req_data.
  - iss_vld <= 1, iss_id <= i.
  - rr_ptr <= (i+1) mod NUM_REQ.
- No handshake: iss_vld <= 0; dp_in holds its value; rr_ptr holds.
- Shadow pipe: NUMBER_OF_STAGES entries of {vld, id}. Entry 0 loads from {iss_vld, iss_id}; each further entry loads from the previous one every cycle. There are no stalls.
- Tail: the last shadow entry, or {iss_vld, iss_id} directly when NUMBER_OF_STAGES = 0.
- rsp_valid = onehot(tail.id) & tail.vld, decoded combinationally. rsp_data = dp_out.
- busy = iss_vld OR any shadow vld.
- The in-flight count never exceeds NUMBER_OF_STAGES+1.

## Timing
- Reset values: dp_in = 0, iss_vld = 0, all shadow vld/id = 0, rr_ptr = 0. Outputs after reset: rsp_valid = 0, busy = 0, req_ready = 0 during reset.
- Latency: handshake at edge t puts the word on dp_in in cycle t+1. The matching rsp_valid is high in cycle t+1+NUMBER_OF_STAGES, for exactly one cycle.
- Throughput: one handshake per cycle, sustained indefinitely. Responses return in issue order.
- Reset mid-operation: all in-flight results are dropped, and no rsp_valid is asserted for them after the reset edge. dp_in is also cleared.
- Single valid requester: granted every cycle, regardless of rr_ptr.
- Wrap: rr_ptr advances from NUM_REQ-1 to 0.

## Configuration
- Macro: PIPELINE_ARBITER_FLUSH_EN.
- Defined: adds port `flush  input  1`. When flush is high at an edge, iss_vld and every shadow vld are cleared, and req_ready is 0 in that cycle. rr_ptr and dp_in hold their values. Results already in the datapath are never reported.
- Undefined: the port is absent and there is no flush logic. Behaviour is otherwise identical.

## Structure
- Shared package/header holds:
  - the ID_W constant, computed as clog2(NUM_REQ), minimum 1;
  - the {vld, id} shadow-entry typedef/field widths;
  - the onehot-to-index and index-to-onehot functions.
- Sub-module rr_grant: takes req_valid and rr_ptr and produces the one-hot grant and the granted index, purely combinationally.
- Shadow pipe: a generate loop over NUMBER_OF_STAGES. The 0-stage case is a direct pass-through.

## Test plan
- Reset then idle: all req_valid = 0 for 20 cycles -> req_ready = 0, rsp_valid = 0, busy = 0, dp_in = 0.
- Single request: req_valid = 4'b0100, data 10'h155 at edge t -> dp_in = 10'h155 at t+1; rsp_valid = 4'b0100 at t+6 only; busy high in cycles t+1..t+6.
- All four valid continuously for 12 cycles -> grants 0,1,2,3,0,1,… every cycle; rsp_valid follows the same order, starting 6 cycles later, with no gaps.
- Requesters 1 and 3 valid, rr_ptr = 2 -> requester 3 granted first, then 1; rr_ptr goes 0 then 2.
- Three requests in flight, rst pulsed for 1 cycle -> no rsp_valid after the reset edge; rr_ptr = 0; the next grant goes to the lowest valid index.
- With PIPELINE_ARBITER_FLUSH_EN: issue 3 requests, flush at the second in-flight edge -> only results issued after the flush appear; req_ready = 0 in the flush cycle.
